// File: rtl/fpu_pkg.sv
// Shared definitions for the FP units: op codes, fflags/fclass bit positions and NaN helpers.
package fpu_pkg;

  localparam logic [5:0] FOP_FCLASS = 6'd8;
  localparam logic [5:0] FOP_FMIN   = 6'd9;
  localparam logic [5:0] FOP_FMAX   = 6'd10;
  localparam logic [5:0] FOP_FSGNJ  = 6'd11;
  localparam logic [5:0] FOP_FSGNJN = 6'd12;
  localparam logic [5:0] FOP_FSGNJX = 6'd13;
  localparam logic [5:0] FOP_FEQ    = 6'd14;
  localparam logic [5:0] FOP_FLT    = 6'd15;
  localparam logic [5:0] FOP_FLE    = 6'd16;

  // fcsr fflags layout {NV,DZ,OF,UF,NX}
  localparam int unsigned FFLAG_NX = 0;
  localparam int unsigned FFLAG_UF = 1;
  localparam int unsigned FFLAG_OF = 2;
  localparam int unsigned FFLAG_DZ = 3;
  localparam int unsigned FFLAG_NV = 4;

  localparam int unsigned FCLASS_NEG_INF  = 0;
  localparam int unsigned FCLASS_NEG_NORM = 1;
  localparam int unsigned FCLASS_NEG_SUB  = 2;
  localparam int unsigned FCLASS_NEG_ZERO = 3;
  localparam int unsigned FCLASS_POS_ZERO = 4;
  localparam int unsigned FCLASS_POS_SUB  = 5;
  localparam int unsigned FCLASS_POS_NORM = 6;
  localparam int unsigned FCLASS_POS_INF  = 7;
  localparam int unsigned FCLASS_SNAN     = 8;
  localparam int unsigned FCLASS_QNAN     = 9;

  // Operands are passed zero-extended to this width so one helper serves every format.
  localparam int unsigned FP_MAX_W = 64;

  // {0, all-ones exponent, quiet bit set, rest of mantissa zero}
  function automatic logic [FP_MAX_W-1:0] canonical_nan(input int unsigned exp_w,
                                                        input int unsigned man_w);
    logic [FP_MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < FP_MAX_W; i++) begin
      if ((i + 1 >= man_w) && (i < man_w + exp_w)) r[i] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic is_nan(input logic [FP_MAX_W-1:0] x, input int unsigned exp_w,
                                  input int unsigned man_w);
    logic exp_ones;
    logic man_nz;
    exp_ones = 1'b1;
    man_nz   = 1'b0;
    for (int unsigned i = 0; i < FP_MAX_W; i++) begin
      if (i < man_w) man_nz = man_nz | x[i];
      else if (i < man_w + exp_w) exp_ones = exp_ones & x[i];
    end
    return exp_ones & man_nz;
  endfunction

  function automatic logic is_snan(input logic [FP_MAX_W-1:0] x, input int unsigned exp_w,
                                   input int unsigned man_w);
    logic quiet;
    quiet = 1'b0;
    for (int unsigned i = 0; i < FP_MAX_W; i++) begin
      if (i + 1 == man_w) quiet = x[i];
    end
    return is_nan(x, exp_w, man_w) & ~quiet;
  endfunction

endpackage

// File: rtl/fpu_result_fifo.sv
// In-order result buffer; the producer is credit-limited so no full check is needed here.
module fpu_result_fifo #(
  parameter int unsigned WIDTH = 43,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_valid_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_ready_i,
  output logic             rd_valid_o,
  output logic [WIDTH-1:0] rd_data_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  assign rd_valid_o = (wr_ptr_q != rd_ptr_q);
  assign rd_data_o  = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer advance; the extra MSB distinguishes full from empty and wraps naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q + (AW+1)'(wr_valid_i);
    rd_ptr_d = rd_ptr_q + (AW+1)'(rd_valid_o && rd_ready_i);
  end

  // Pointer registers, cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are don't-care until a pointer covers them.
  always_ff @(posedge clk_i) begin
    if (wr_valid_i) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/fpu_misc_pipe.sv
// Non-arithmetic F-extension ops (sign-inject, min/max, class, compare) behind a fixed-latency
// pipe and a credit-guarded result FIFO, with sticky accrued fflags.
module fpu_misc_pipe
  import fpu_pkg::*;
#(
  parameter int unsigned FLEN       = 32,
  parameter int unsigned EXP_W      = 8,
  parameter int unsigned MAN_W      = 23,
  parameter int unsigned STAGES     = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TAG_W      = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_op,
  input  logic [FLEN-1:0]  in_rs1,
  input  logic [FLEN-1:0]  in_rs2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [FLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic [4:0]       out_flags,
  output logic             out_illegal,
  output logic [4:0]       fflags,
  input  logic             fflags_clr
);

  localparam int unsigned PW   = FLEN + TAG_W + 6;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [FLEN-1:0] CanonNan = FLEN'(canonical_nan(EXP_W, MAN_W));

  function automatic logic [9:0] classify(input logic [FLEN-1:0] x);
    logic       s, eo, ez, mz, quiet;
    logic [9:0] c;
    s     = x[FLEN-1];
    eo    = &x[FLEN-2:MAN_W];
    ez    = ~|x[FLEN-2:MAN_W];
    mz    = ~|x[MAN_W-1:0];
    quiet = x[MAN_W-1];
    c     = '0;
    if (eo && mz) begin
      if (s) c[FCLASS_NEG_INF] = 1'b1;
      else   c[FCLASS_POS_INF] = 1'b1;
    end else if (eo) begin
      if (quiet) c[FCLASS_QNAN] = 1'b1;
      else       c[FCLASS_SNAN] = 1'b1;
    end else if (ez && mz) begin
      if (s) c[FCLASS_NEG_ZERO] = 1'b1;
      else   c[FCLASS_POS_ZERO] = 1'b1;
    end else if (ez) begin
      if (s) c[FCLASS_NEG_SUB] = 1'b1;
      else   c[FCLASS_POS_SUB] = 1'b1;
    end else begin
      if (s) c[FCLASS_NEG_NORM] = 1'b1;
      else   c[FCLASS_POS_NORM] = 1'b1;
    end
    return c;
  endfunction

  logic             accept, out_hs;
  logic             s1, s2, nan1, nan2, snan1, snan2, both_zero;
  logic [FLEN-2:0]  mag1, mag2;
  logic             lt_tot, flt_v, feq_v;
  logic [FLEN-1:0]  op_result;
  logic [4:0]       op_flags;
  logic             op_illegal;
  logic [PW-1:0]    payload;

  logic [STAGES-1:0] pipe_valid_q, pipe_valid_d;
  logic [PW-1:0]     pipe_data_q [STAGES];
  logic [PW-1:0]     pipe_data_d [STAGES];
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [4:0]        fflags_q, fflags_d;
  logic [PW-1:0]     fifo_rd_data;

  assign in_ready = !reset && (cnt_q < CntW'(FIFO_DEPTH));
  assign accept   = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;

  // Operand decode shared by min/max and the compares.
  always_comb begin
    s1    = in_rs1[FLEN-1];
    s2    = in_rs2[FLEN-1];
    mag1  = in_rs1[FLEN-2:0];
    mag2  = in_rs2[FLEN-2:0];
    nan1  = is_nan(FP_MAX_W'(in_rs1), EXP_W, MAN_W);
    nan2  = is_nan(FP_MAX_W'(in_rs2), EXP_W, MAN_W);
    snan1 = is_snan(FP_MAX_W'(in_rs1), EXP_W, MAN_W);
    snan2 = is_snan(FP_MAX_W'(in_rs2), EXP_W, MAN_W);
    both_zero = ~|mag1 & ~|mag2;
    // Total order on non-NaN values with -0 below +0; compares then fold the zeros together.
    if (s1 != s2) lt_tot = s1;
    else if (s1)  lt_tot = (mag1 > mag2);
    else          lt_tot = (mag1 < mag2);
    flt_v = lt_tot & ~both_zero;
    feq_v = (in_rs1 == in_rs2) | both_zero;
  end

  // Op evaluation; everything resolves before the first pipe register.
  always_comb begin
    op_result  = '0;
    op_flags   = '0;
    op_illegal = 1'b0;
    case (in_op)
      FOP_FCLASS: op_result = FLEN'(classify(in_rs1));
      FOP_FMIN, FOP_FMAX: begin
        op_flags[FFLAG_NV] = snan1 | snan2;
        if (nan1 && nan2)  op_result = CanonNan;
        else if (nan1)     op_result = in_rs2;
        else if (nan2)     op_result = in_rs1;
        else if ((in_op == FOP_FMIN) == lt_tot) op_result = in_rs1;
        else               op_result = in_rs2;
      end
      FOP_FSGNJ:  op_result = {s2, in_rs1[FLEN-2:0]};
      FOP_FSGNJN: op_result = {~s2, in_rs1[FLEN-2:0]};
      FOP_FSGNJX: op_result = {s1 ^ s2, in_rs1[FLEN-2:0]};
      FOP_FEQ: begin
        if (nan1 || nan2) op_flags[FFLAG_NV] = snan1 | snan2;
        else              op_result = FLEN'(feq_v);
      end
      FOP_FLT: begin
        if (nan1 || nan2) op_flags[FFLAG_NV] = 1'b1;
        else              op_result = FLEN'(flt_v);
      end
      FOP_FLE: begin
        if (nan1 || nan2) op_flags[FFLAG_NV] = 1'b1;
        else              op_result = FLEN'(flt_v | feq_v);
      end
      default: op_illegal = 1'b1;
    endcase
    payload = {op_illegal, op_flags, in_tag, op_result};
  end

  // Fixed-latency shift pipe; never stalls because credits reserve a FIFO slot per op.
  always_comb begin
    pipe_valid_d[0] = accept;
    pipe_data_d[0]  = payload;
    for (int unsigned i = 1; i < STAGES; i++) begin
      pipe_valid_d[i] = pipe_valid_q[i-1];
      pipe_data_d[i]  = pipe_data_q[i-1];
    end
  end

  // Pipe registers; reset drops in-flight ops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_valid_q <= '0;
      for (int unsigned i = 0; i < STAGES; i++) pipe_data_q[i] <= '0;
    end else begin
      pipe_valid_q <= pipe_valid_d;
      for (int unsigned i = 0; i < STAGES; i++) pipe_data_q[i] <= pipe_data_d[i];
    end
  end

  // Credits = ops in pipe + FIFO occupancy; clear-then-accumulate for fflags.
  always_comb begin
    cnt_d    = cnt_q + CntW'(accept) - CntW'(out_hs);
    fflags_d = (fflags_clr ? 5'b0 : fflags_q) | (out_hs ? out_flags : 5'b0);
  end

  // Credit counter and sticky flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      fflags_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      fflags_q <= fflags_d;
    end
  end

  fpu_result_fifo #(
    .WIDTH (PW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk),
    .rst_i      (reset),
    .wr_valid_i (pipe_valid_q[STAGES-1]),
    .wr_data_i  (pipe_data_q[STAGES-1]),
    .rd_ready_i (out_ready),
    .rd_valid_o (out_valid),
    .rd_data_o  (fifo_rd_data)
  );

  assign {out_illegal, out_flags, out_tag, out_result} = fifo_rd_data;
  assign fflags = fflags_q;

endmodule

// File: tb/tb_fpu_misc_pipe.sv
module tb_fpu_misc_pipe;

  typedef struct packed {
    logic        ill;
    logic [4:0]  flags;
    logic [4:0]  tag;
    logic [31:0] res;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, out_valid, out_ready, out_illegal, fflags_clr;
  logic [5:0]  in_op;
  logic [31:0] in_rs1, in_rs2, out_result;
  logic [4:0]  in_tag, out_tag, out_flags, fflags;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  logic [4:0] m_fflags = 5'b0;
  logic [31:0] vals [8];

  always #5 clk = ~clk;

  fpu_misc_pipe dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .out_flags  (out_flags),
    .out_illegal(out_illegal),
    .fflags     (fflags),
    .fflags_clr (fflags_clr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit m_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 0);
  endfunction

  function automatic bit m_snan(input logic [31:0] x);
    return m_nan(x) && !x[22];
  endfunction

  function automatic int cls_idx(input logic [31:0] x);
    if (x[30:23] == 8'hFF) return (x[22:0] == 0) ? (x[31] ? 0 : 7) : (x[22] ? 9 : 8);
    if (x[30:23] == 8'h00) return (x[22:0] == 0) ? (x[31] ? 3 : 4) : (x[31] ? 2 : 5);
    return x[31] ? 1 : 6;
  endfunction

  // Numeric key: equal for +0/-0.
  function automatic longint key(input logic [31:0] x);
    longint m;
    m = longint'({33'b0, x[30:0]});
    return x[31] ? -m : m;
  endfunction

  // Key for min/max where -0 sits below +0.
  function automatic longint key_mm(input logic [31:0] x);
    longint m;
    m = longint'({33'b0, x[30:0]});
    return x[31] ? -m - 1 : m;
  endfunction

  function automatic exp_t model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] tag);
    exp_t e;
    e = '0;
    e.tag = tag;
    case (op)
      6'd8: e.res = 32'd1 << cls_idx(a);
      6'd9, 6'd10: begin
        e.flags = {(m_snan(a) || m_snan(b)), 4'b0};
        if (m_nan(a) && m_nan(b)) e.res = 32'h7FC00000;
        else if (m_nan(a))        e.res = b;
        else if (m_nan(b))        e.res = a;
        else if (op == 6'd9)      e.res = (key_mm(a) <= key_mm(b)) ? a : b;
        else                      e.res = (key_mm(a) >= key_mm(b)) ? a : b;
      end
      6'd11: e.res = {b[31], a[30:0]};
      6'd12: e.res = {~b[31], a[30:0]};
      6'd13: e.res = {a[31] ^ b[31], a[30:0]};
      6'd14: begin
        if (m_nan(a) || m_nan(b)) e.flags = {(m_snan(a) || m_snan(b)), 4'b0};
        else e.res = (key(a) == key(b)) ? 32'd1 : 32'd0;
      end
      6'd15: begin
        if (m_nan(a) || m_nan(b)) e.flags = 5'h10;
        else e.res = (key(a) < key(b)) ? 32'd1 : 32'd0;
      end
      6'd16: begin
        if (m_nan(a) || m_nan(b)) e.flags = 5'h10;
        else e.res = (key(a) <= key(b)) ? 32'd1 : 32'd0;
      end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  // ---------------- cycle compare against the model ----------------
  always @(negedge clk) begin
    exp_t h;
    logic hs, exp_rdy;
    if (reset) begin
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_fflags", fflags, 0);
      q.delete();
      m_fflags = 5'b0;
    end else begin
      exp_rdy = (q.size() < 4);
      chk("in_ready", in_ready, exp_rdy);
      chk("fflags", fflags, m_fflags);
      hs = 1'b0;
      h  = '0;
      if (out_valid) begin
        chk("result_outstanding", q.size() != 0, 1);
        if (q.size() != 0) begin
          h = q[0];
          chk("out_result", out_result, h.res);
          chk("out_tag", out_tag, h.tag);
          chk("out_flags", out_flags, h.flags);
          chk("out_illegal", out_illegal, h.ill);
          hs = out_ready;
        end
      end
      m_fflags = (fflags_clr ? 5'b0 : m_fflags) | (hs ? h.flags : 5'b0);
      if (hs) void'(q.pop_front());
      if (in_valid && exp_rdy) q.push_back(model(in_op, in_rs1, in_rs2, in_tag));
    end
  end

  // ---------------- directed stimulus ----------------
  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic do_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag);
    in_op = op; in_rs1 = a; in_rs2 = b; in_tag = tag; in_valid = 1'b1;
    @(negedge clk);
    chk("accept_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input string name, input logic [31:0] res, input logic [4:0] flags,
                             input logic ill, input logic [4:0] tag, output int lat);
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: out_valid still 0 after 20 cycles, expected 1", name);
    end else begin
      chk({name, "_result"}, out_result, res);
      chk({name, "_flags"}, out_flags, flags);
      chk({name, "_illegal"}, out_illegal, ill);
      chk({name, "_tag"}, out_tag, tag);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t e;
    int lat, acc, n;
    logic [5:0] op;
    vals = '{32'h00000000, 32'h80000000, 32'h3F800000, 32'hBF800000,
             32'h7F800000, 32'h7FC00000, 32'h7F800001, 32'h00000001};
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; fflags_clr = 1'b0;
    in_op = '0; in_rs1 = '0; in_rs2 = '0; in_tag = '0;

    // Hand-computed pins on the model itself.
    e = model(6'd12, 32'h3F800000, 32'h3F800000, 5'd3);
    chk("model_fsgnjn", e.res, 32'hBF800000);
    e = model(6'd9, 32'h7F800001, 32'h40000000, 5'd0);
    chk("model_fmin_res", e.res, 32'h40000000);
    chk("model_fmin_flags", e.flags, 5'h10);
    e = model(6'd14, 32'h80000000, 32'h00000000, 5'd0);
    chk("model_feq_zero", e.res, 32'd1);
    e = model(6'd8, 32'h00000001, 32'h0, 5'd0);
    chk("model_fclass_sub", e.res, 32'h020);
    e = model(6'd10, 32'h80000000, 32'h00000000, 5'd0);
    chk("model_fmax_zero", e.res, 32'h00000000);

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", in_ready, 1);
    @(posedge clk); #1;

    do_op(6'd12, 32'h3F800000, 32'h3F800000, 5'd3);
    wait_result("fsgnjn", 32'hBF800000, 5'h0, 1'b0, 5'd3, lat);
    chk("latency", lat, 3);
    do_op(6'd9, 32'h7F800001, 32'h40000000, 5'd1);
    wait_result("fmin_snan", 32'h40000000, 5'h10, 1'b0, 5'd1, lat);
    do_op(6'd10, 32'h7FC00000, 32'h7FC00000, 5'd2);
    wait_result("fmax_qnan", 32'h7FC00000, 5'h0, 1'b0, 5'd2, lat);
    chk("fflags_sticky", fflags, 5'h10);
    do_op(6'd14, 32'h7FC00000, 32'h0, 5'd4);
    wait_result("feq_qnan", 32'h0, 5'h0, 1'b0, 5'd4, lat);
    do_op(6'd15, 32'h7FC00000, 32'h0, 5'd5);
    wait_result("flt_qnan", 32'h0, 5'h10, 1'b0, 5'd5, lat);
    do_op(6'd16, 32'h80000000, 32'h00000000, 5'd6);
    wait_result("fle_zeros", 32'h1, 5'h0, 1'b0, 5'd6, lat);
    do_op(6'd14, 32'h80000000, 32'h00000000, 5'd7);
    wait_result("feq_zeros", 32'h1, 5'h0, 1'b0, 5'd7, lat);
    do_op(6'd13, 32'hBF800000, 32'hC0000000, 5'd8);
    wait_result("fsgnjx", 32'h3F800000, 5'h0, 1'b0, 5'd8, lat);
    do_op(6'd8, 32'hFF800000, 32'h0, 5'd9);
    wait_result("fclass_ninf", 32'h001, 5'h0, 1'b0, 5'd9, lat);
    do_op(6'd8, 32'h00000001, 32'h0, 5'd10);
    wait_result("fclass_psub", 32'h020, 5'h0, 1'b0, 5'd10, lat);
    do_op(6'd8, 32'h7F800001, 32'h0, 5'd11);
    wait_result("fclass_snan", 32'h100, 5'h0, 1'b0, 5'd11, lat);
    do_op(6'd8, 32'h7FC00000, 32'h0, 5'd12);
    wait_result("fclass_qnan", 32'h200, 5'h0, 1'b0, 5'd12, lat);
    do_op(6'd20, 32'h3F800000, 32'h3F800000, 5'd13);
    wait_result("illegal", 32'h0, 5'h0, 1'b1, 5'd13, lat);

    // Backpressure: consumer stalled, six back-to-back offers.
    out_ready = 1'b0;
    acc = 0;
    for (int t = 0; t < 6; t++) begin
      in_op = 6'd11; in_rs1 = 32'h40000000 + t; in_rs2 = 32'h80000000; in_tag = 5'(t);
      in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) acc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("bp_accepted", acc, 4);
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    n = 0;
    for (int k = 0; k < 20 && n < 4; k++) begin
      @(negedge clk);
      if (out_valid) begin
        chk("bp_order_tag", out_tag, 5'(n));
        n++;
      end
    end
    chk("bp_drained", n, 4);
    @(negedge clk);
    chk("bp_ready_again", in_ready, 1);
    chk("bp_empty", out_valid, 0);
    @(posedge clk); #1;

    // Mixed ops with intermittent consumer stalls, checked by the model.
    for (int i = 0; i < 18; i++) begin
      op = 6'(8 + (i % 9));
      in_op = op; in_rs1 = vals[i % 8]; in_rs2 = vals[(i * 3 + 1) % 8]; in_tag = 5'(i);
      in_valid = 1'b1;
      out_ready = (i % 3 != 0);
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (in_ready) break;
        if (k == 19) begin
          checks++;
          errors++;
          $display("FAIL mix_accept_timeout: in_ready 0 for 20 cycles, expected 1");
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("mix_all_returned", q.size(), 0);

    // Reset with ops in flight.
    chk("fflags_before_reset", fflags, 5'h10);
    do_op(6'd12, 32'h3F800000, 32'h0, 5'd20);
    do_op(6'd9, 32'h7F800001, 32'h0, 5'd21);
    reset = 1'b1;
    #1;
    chk("rst_now_out_valid", out_valid, 0);
    chk("rst_now_fflags", fflags, 0);
    chk("rst_now_in_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_release_ready", in_ready, 1);
    repeat (8) begin
      @(negedge clk);
      chk("rst_no_stale", out_valid, 0);
    end
    @(posedge clk); #1;

    // fflags_clr against a coincident handshake.
    do_op(6'd15, 32'h7FC00000, 32'h0, 5'd22);
    wait_result("flt_nv", 32'h0, 5'h10, 1'b0, 5'd22, lat);
    chk("fflags_nv_set", fflags, 5'h10);
    do_op(6'd14, 32'h0, 32'h0, 5'd23);
    @(posedge clk); #1;
    @(posedge clk); #1;
    fflags_clr = 1'b1;
    @(posedge clk); #1;
    fflags_clr = 1'b0;
    chk("clr_with_clean_result", fflags, 5'h00);
    do_op(6'd15, 32'h7FC00000, 32'h0, 5'd24);
    @(posedge clk); #1;
    @(posedge clk); #1;
    fflags_clr = 1'b1;
    @(posedge clk); #1;
    fflags_clr = 1'b0;
    chk("clr_with_nv_result", fflags, 5'h10);
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
